// File: rtl/top_conv3x3.sv
// top_conv3x3 - streaming 3x3 convolution over a raster-order 8-bit image.
//
// A window result is produced for every accepted pixel at row >= 2 and
// col >= 2. Nine signed 16-bit coefficients are applied. The 32-bit sum is
// shifted right arithmetically by SHIFT and then clamped to 0..255.
//
// Parameters:
//   IMG_W, IMG_H   image size in pixels (each >= 3)
//   SHIFT          arithmetic right shift applied to the sum
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   k_val[143:0]   coefficient i = 3*r + c at [16i+15:16i]; r=0 is top row, c=0 is left column
//   pixel_i[7:0]   unsigned input pixel
//   pix_data_valid pixel_i accepted on this edge
//   pixel_o[7:0]   clamped result; meaningful only while conv_finished is high
//   conv_finished  one-cycle strobe per result, 2 edges after the window-completing pixel
module top_conv3x3 #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int SHIFT = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [143:0] k_val,
  input  logic [7:0]   pixel_i,
  input  logic         pix_data_valid,
  output logic [7:0]   pixel_o,
  output logic         conv_finished
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic          accept;
  logic [CW-1:0] col_reg, col_next;
  logic [RW-1:0] row_reg, row_next;

  assign accept = pix_data_valid & ~rst_i;

  // Raster position of the next pixel to be accepted.
  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (rst_i) begin
      col_next = '0;
      row_next = '0;
    end else if (pix_data_valid) begin
      if (col_reg == COL_LAST) begin
        col_next = '0;
        row_next = (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
      end else begin
        col_next = col_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    col_reg <= col_next;
    row_reg <= row_next;
  end

  // Line buffers: line1 holds the previous row and line2 holds the row
  // before it. Reads are registered. The read address is the column of the
  // next pixel to be accepted, so the taps are ready when that pixel arrives.
  // A write and a read on the same edge always use different columns.
  logic [7:0] line1_mem [IMG_W];
  logic [7:0] line2_mem [IMG_W];
  logic [7:0] tap1_reg;
  logic [7:0] tap2_reg;

  always_ff @(posedge clk_i) begin
    if (accept) begin
      line1_mem[col_reg] <= pixel_i;
      line2_mem[col_reg] <= tap1_reg;
    end
    tap1_reg <= line1_mem[col_next];
    tap2_reg <= line2_mem[col_next];
  end

  // 3x3 window, index 3*r + c. Column 2 is the newest column.
  logic [7:0] win_reg [9];
  logic       win_valid_reg;

  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_reg[3*r]   <= win_reg[3*r+1];
        win_reg[3*r+1] <= win_reg[3*r+2];
      end
      win_reg[2] <= tap2_reg;
      win_reg[5] <= tap1_reg;
      win_reg[8] <= pixel_i;
    end
  end

  // Stage 1: nine 25-bit signed products.
  logic signed [24:0] prod [9];
  logic signed [24:0] prod_reg [9];
  logic               prod_valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_mult
      assign prod[gi] = 25'($signed({1'b0, win_reg[gi]})) *
                        25'($signed(k_val[16*gi +: 16]));
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 9; i++) begin
      prod_reg[i] <= prod[i];
    end
  end

  // Stage 2: sum, shift and clamp.
  logic signed [31:0] sum;
  logic signed [31:0] shifted;
  logic [7:0]         clamped;

  always_comb begin
    sum = '0;
    for (int i = 0; i < 9; i++) begin
      sum = sum + 32'(prod_reg[i]);
    end
    shifted = sum >>> SHIFT;
    if (shifted[31]) begin
      clamped = 8'd0;
    end else if (shifted > 32'sd255) begin
      clamped = 8'd255;
    end else begin
      clamped = shifted[7:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      win_valid_reg  <= 1'b0;
      prod_valid_reg <= 1'b0;
      conv_finished  <= 1'b0;
      pixel_o        <= 8'd0;
    end else begin
      win_valid_reg  <= accept && (row_reg >= ROW_TWO) && (col_reg >= COL_TWO);
      prod_valid_reg <= win_valid_reg;
      conv_finished  <= prod_valid_reg;
      if (prod_valid_reg) begin
        pixel_o <= clamped;
      end
    end
  end

endmodule

// File: tb/tb_top_conv3x3.sv
// tb_top_conv3x3 - self-checking bench for top_conv3x3.
//
// Two instances share all inputs: u_a uses SHIFT=4 and u_b uses SHIFT=0.
// Each frame's output stream is collected and compared with a direct
// per-window convolution computed from the stored image.
module tb_top_conv3x3;

  localparam int W = 28;
  localparam int H = 28;
  localparam int NRES = (W - 2) * (H - 2);

  logic         clk = 1'b0;
  logic         rst;
  logic [143:0] k;
  logic [7:0]   pix;
  logic         vld;
  logic [7:0]   po_a, po_b;
  logic         fin_a, fin_b;

  always #5 clk = ~clk;

  top_conv3x3 #(.IMG_W(W), .IMG_H(H), .SHIFT(4)) u_a (
    .clk_i(clk), .rst_i(rst), .k_val(k), .pixel_i(pix),
    .pix_data_valid(vld), .pixel_o(po_a), .conv_finished(fin_a)
  );

  top_conv3x3 #(.IMG_W(W), .IMG_H(H), .SHIFT(0)) u_b (
    .clk_i(clk), .rst_i(rst), .k_val(k), .pixel_i(pix),
    .pix_data_valid(vld), .pixel_o(po_b), .conv_finished(fin_b)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Cycle counter and reset history for the monitors.
  int   cyc = 0;
  logic rst_q = 1'b0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  int q_a[$], q_b[$];
  int exp_a[$], exp_b[$];
  int first_cyc = -1;

  always @(negedge clk) begin
    if (rst_q) begin
      check("rst_fin_a", 32'(fin_a), 0);
      check("rst_pix_a", 32'(po_a), 0);
      check("rst_fin_b", 32'(fin_b), 0);
      check("rst_pix_b", 32'(po_b), 0);
    end else begin
      if (fin_a) begin
        q_a.push_back(int'(po_a));
        if (first_cyc < 0) first_cyc = cyc;
      end
      if (fin_b) q_b.push_back(int'(po_b));
    end
  end

  // Image store and reference model.
  int img [H][W];

  task automatic fill(input int pat, input int val);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        case (pat)
          0:       img[r][c] = val;
          1:       img[r][c] = (r == 5 && c == 5) ? val : 0;
          2:       img[r][c] = (r * W + c) % 256;
          default: img[r][c] = int'($urandom_range(255));
        endcase
      end
    end
  endtask

  function automatic int clamp8(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  task automatic add_expected(input logic [143:0] kv);
    int acc;
    for (int r = 2; r < H; r++) begin
      for (int c = 2; c < W; c++) begin
        acc = 0;
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            acc += int'($signed(kv[16*(3*i+j) +: 16])) * img[r-2+i][c-2+j];
          end
        end
        exp_a.push_back(clamp8(acc >>> 4));
        exp_b.push_back(clamp8(acc));
      end
    end
  endtask

  function automatic logic [143:0] pack9(input int c0, input int c1, input int c2,
                                         input int c3, input int c4, input int c5,
                                         input int c6, input int c7, input int c8);
    logic [143:0] v;
    v = {16'(c8), 16'(c7), 16'(c6), 16'(c5), 16'(c4), 16'(c3), 16'(c2), 16'(c1), 16'(c0)};
    return v;
  endfunction

  int acc_cnt;
  int acc59_cyc;

  task automatic stream(input int npix, input int gap_pct);
    for (int p = 0; p < npix; p++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        vld = 1'b0;
        pix = 8'($urandom);
        @(posedge clk); #1;
      end
      vld = 1'b1;
      pix = 8'(img[(p / W) % H][p % W]);
      @(posedge clk); #1;
      acc_cnt++;
      if (acc_cnt == 59) acc59_cyc = cyc;
    end
    vld = 1'b0;
  endtask

  task automatic drain();
    vld = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic compare(input string tag);
    check({tag, "_count_a"}, q_a.size(), exp_a.size());
    check({tag, "_count_b"}, q_b.size(), exp_b.size());
    for (int i = 0; i < q_a.size() && i < exp_a.size(); i++)
      check($sformatf("%s_a[%0d]", tag, i), q_a[i], exp_a[i]);
    for (int i = 0; i < q_b.size() && i < exp_b.size(); i++)
      check($sformatf("%s_b[%0d]", tag, i), q_b[i], exp_b[i]);
    $display("run %s: %0d/%0d results (shift4/shift0)", tag, q_a.size(), q_b.size());
    q_a.delete(); q_b.delete(); exp_a.delete(); exp_b.delete();
  endtask

  typedef struct {
    string        name;
    int           pat;
    int           val;
    logic [143:0] kv;
    int           gap;
    int           exp_a;   // constant for every result, or -1 for the model
    int           exp_b;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2ms;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int nz;
    vecs[0] = '{"flat_gauss", 0, 100, pack9(1,2,1,2,4,2,1,2,1), 0, 100, 255};
    vecs[1] = '{"impulse",    1, 200, pack9(0,0,0,0,1,0,0,0,0), 0, -1, -1};
    vecs[2] = '{"sat_hi",     0, 255, pack9(1,1,1,1,1,1,1,1,1), 0, 143, 255};
    vecs[3] = '{"sat_lo",     0, 255, pack9(-1,-1,-1,-1,-1,-1,-1,-1,-1), 0, 0, 0};
    vecs[4] = '{"ramp",       2, 0,   pack9(1,2,1,2,4,2,1,2,1), 0, -1, -1};
    vecs[5] = '{"ramp_gaps",  2, 0,   pack9(1,2,1,2,4,2,1,2,1), 30, -1, -1};
    vecs[6] = '{"rand",       3, 0,
                pack9(int'($urandom_range(48)) - 24, int'($urandom_range(48)) - 24,
                      int'($urandom_range(48)) - 24, int'($urandom_range(48)) - 24,
                      int'($urandom_range(64)) - 16, int'($urandom_range(48)) - 24,
                      int'($urandom_range(48)) - 24, int'($urandom_range(48)) - 24,
                      int'($urandom_range(48)) - 24), 20, -1, -1};

    // Reset with valid input present: outputs must stay at zero.
    rst = 1'b1; vld = 1'b1; k = '0; pix = 8'd0;
    for (int i = 0; i < 5; i++) begin
      pix = 8'($urandom);
      @(posedge clk); #1;
    end
    rst = 1'b0; vld = 1'b0;

    for (int t = 0; t < 7; t++) begin
      k = vecs[t].kv;
      fill(vecs[t].pat, vecs[t].val);
      if (vecs[t].exp_a < 0) begin
        add_expected(vecs[t].kv);
      end else begin
        for (int i = 0; i < NRES; i++) begin
          exp_a.push_back(vecs[t].exp_a);
          exp_b.push_back(vecs[t].exp_b);
        end
      end
      acc_cnt = 0;
      first_cyc = -1;
      stream(W * H, vecs[t].gap);
      drain();
      if (t == 0) check("latency_pix59", first_cyc - acc59_cyc, 2);
      if (t == 1) begin
        check("impulse_b_108", (q_b.size() > 108) ? q_b[108] : -1, 200);
        check("impulse_a_108", (q_a.size() > 108) ? q_a[108] : -1, 12);
        nz = 0;
        foreach (q_b[i]) if (q_b[i] != 0) nz++;
        check("impulse_nonzero", nz, 1);
      end
      compare(vecs[t].name);
    end

    // Two frames back to back with no idle cycle between them.
    k = pack9(1,2,1,2,4,2,1,2,1);
    fill(3, 0);
    add_expected(k);
    stream(W * H, 0);
    fill(3, 0);
    add_expected(k);
    stream(W * H, 0);
    drain();
    compare("b2b");

    // Mid-frame reset at pixel 400, then a clean full frame.
    k = pack9(-1,2,-1,3,5,3,-1,2,-1);
    fill(3, 0);
    stream(400, 0);
    rst = 1'b1; vld = 1'b1; pix = 8'($urandom);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; vld = 1'b0;
    q_a.delete(); q_b.delete();
    fill(3, 0);
    add_expected(k);
    stream(W * H, 10);
    drain();
    compare("mid_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
